ysyx_25010008_axi_rr_arb: RTL and testbench
===========================================

YSYX_25010008_AXI_RR_ARB -- requirements
Module: ysyx_25010008_axi_rr_arb

Interface
REQ-001 Parameter: M0_ID, 4'd0, AXI ID driven for IFU (M0) transactions.
REQ-002 Parameter: M1_ID, 4'd1, AXI ID driven for LSU (M1) transactions.
REQ-003 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 Port: m0_ar{valid,ready,addr,len}  in/out/in/in  1/1/32/8  IFU read address, arsize fixed 3'b010.
REQ-006 Port: m0_r{valid,ready,data,resp,last}  out/in/out/out/out  1/1/32/2/1  IFU read data.
REQ-007 Port: m1_ar{valid,ready,addr,size}  in/out/in/in  1/1/32/3  LSU read address, single beat.
REQ-008 Port: m1_r{valid,ready,data,resp}  out/in/out/out  1/1/32/2  LSU read data.
REQ-009 Port: m1_aw{valid,ready,addr,size}, m1_w{valid,ready,data,strb}, m1_b{valid,ready,resp}  LSU single-beat write channels.
REQ-010 Port: io_master_* full AXI4 master set (aw/w/b/ar/r, widths per AXI4, id 4, addr/data 32)  out/in  downstream bus.

Function
REQ-011 Exactly one transaction outstanding on io_master at any time; reads and writes serialized.
REQ-012 FSM states: IDLE, RD0, RD1, WR; state register only, grant implied by state.
REQ-013 IDLE: requests sampled are m0_arvalid (R0), m1_arvalid (R1), m1_awvalid (W1); M1 read and write mutually exclusive by LSU contract; W1 wins over R1 if both high.
REQ-014 IDLE->RDx/WR on the cycle a request is selected; io_master_arvalid/awvalid asserted from the next cycle (1-cycle grant latency).
REQ-015 RDx: io_master_ar* driven from granted master, arid = Mx_ID, arburst 2'b01, M1 arlen 0; mx_arready = io_master_arready; AR accepted once, tracked by ar_done flag.
REQ-016 RDx: io_master_r* routed to granted master only; non-granted rvalid = 0; io_master_rready = granted rready.
REQ-017 RD0->IDLE on rvalid&rready&rlast; RD1->IDLE on first rvalid&rready (ignore rlast).
REQ-018 WR: AW and W issued concurrently, awlen 0, wlast 1, awid = M1_ID; aw_done/w_done flags set independently on handshake; bready = m1_bready once both done.
REQ-019 WR->IDLE on bvalid&bready; bresp passed through unchanged.
REQ-020 rresp/bresp != OKAY forwarded unchanged; arbiter takes no other action.
REQ-021 Mid-transaction requests from the other master held (arready 0) until return to IDLE; no preemption.
REQ-022 IFU burst of length arlen+1 beats completes contiguously without interleaving M1 beats.

Reset
REQ-023 reset=0 at a clock edge: state=IDLE, last_grant=M1, all done flags 0, all valid/ready outputs 0, same-edge deassert takes effect next cycle.
REQ-024 Reset mid-transaction abandons it; downstream is reset by the same signal.

Configuration
REQ-025 Macro YSYX_25010008_ARB_RR_EN defined: in IDLE with R0 and (R1|W1) both pending, grant the master not in last_grant; last_grant updated on each grant.
REQ-026 Macro undefined: fixed priority, M1 always wins contention; last_grant register omitted.

Structure
REQ-027 Shared package holds FSM state enum, AXI burst/resp constants (INCR=2'b01, OKAY=2'b00), default IDs.
REQ-028 No sub-module; mux/FSM inline, target 150-300 lines.

Verification
REQ-029 Reset: hold reset=0 3 cycles -> all io_master valids 0, m0_arready=m1_arready=0.
REQ-030 M0 arvalid, addr 0x3000_0000, len 3 -> io_master_arvalid next cycle, arid 0, arlen 3, 4 beats to M0, IDLE after rlast.
REQ-031 M1 store addr 0x8000_0010, data 0xDEADBEEF, strb 4'b1111; AW ready delayed 2 cycles after W -> single wvalid beat, wlast 1, b delivered to M1, IDLE.
REQ-032 R0 and R1 simultaneous from reset, RR_EN defined -> M0 first (last_grant=M1), then M1; undefined -> M1 first.
REQ-033 M1 read during active M0 burst -> m1_arready 0 until M0 rlast, M1 granted next IDLE.
REQ-034 Downstream rresp=2'b10 on M1 read -> m1_rresp 2'b10, FSM to IDLE, next request served normally.

Source files
------------

// File: rtl/ysyx_25010008_axi_rr_arb_pkg.sv
// Shared types and constants for the IFU/LSU AXI read/write arbiter.
package ysyx_25010008_axi_rr_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned LEN_W  = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  localparam logic [ID_W-1:0] DEF_M0_ID = 4'd0;
  localparam logic [ID_W-1:0] DEF_M1_ID = 4'd1;

  // Grant is implied by the state: RD0 = IFU read, RD1 = LSU read, WR = LSU write
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_e;

endpackage

// File: rtl/ysyx_25010008_axi_rr_arb_if.sv
// AXI4 bundle (aw/w/b/ar/r) shared by the upstream masters and the downstream bus.
interface ysyx_25010008_axi_rr_arb_if;
  import ysyx_25010008_axi_rr_arb_pkg::*;

  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready, rlast;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rdata, rresp, rlast, output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready
  );

endinterface

// File: rtl/ysyx_25010008_axi_rr_arb.sv
// IFU (m0, read bursts) / LSU (m1, single-beat read/write) arbiter onto one AXI4 master.
// One transaction outstanding at a time. Optional round-robin contention handling
// is enabled with the macro YSYX_25010008_ARB_RR_EN; otherwise the LSU always wins.
module ysyx_25010008_axi_rr_arb
  import ysyx_25010008_axi_rr_arb_pkg::*;
#(
  parameter logic [ID_W-1:0] M0_ID = DEF_M0_ID,
  parameter logic [ID_W-1:0] M1_ID = DEF_M1_ID
) (
  input logic                           clock,
  input logic                           reset,
  ysyx_25010008_axi_rr_arb_if.slave     m0,
  ysyx_25010008_axi_rr_arb_if.slave     m1,
  ysyx_25010008_axi_rr_arb_if.master    io_master
);

  state_e state_q, state_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   pick_m0;
  logic   wr_both;
`ifdef YSYX_25010008_ARB_RR_EN
  grant_e last_grant_q, last_grant_d;
`endif

  // Upstream inputs the arbiter never consumes (IFU has no write path, fixed-shape LSU fields)
  logic unused_sig;
  assign unused_sig = ^{m0.awvalid, m0.awid, m0.awaddr, m0.awlen, m0.awsize, m0.awburst,
                        m0.wvalid, m0.wdata, m0.wstrb, m0.wlast, m0.bready,
                        m0.arid, m0.arsize, m0.arburst,
                        m1.arid, m1.arlen, m1.arburst, m1.awid, m1.awlen, m1.awburst, m1.wlast};

  // State and handshake-tracking registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
`ifdef YSYX_25010008_ARB_RR_EN
      last_grant_q <= GNT_M1;
`endif
    end else begin
      state_q      <= state_d;
      ar_done_q    <= ar_done_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
`ifdef YSYX_25010008_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Arbitration, next state and channel muxing for the granted master
  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    pick_m0   = 1'b0;
    wr_both   = aw_done_q && w_done_q;
`ifdef YSYX_25010008_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    io_master.arvalid = 1'b0;
    io_master.arid    = M0_ID;
    io_master.araddr  = '0;
    io_master.arlen   = '0;
    io_master.arsize  = SIZE_WORD;
    io_master.arburst = BURST_INCR;
    io_master.rready  = 1'b0;
    io_master.awvalid = 1'b0;
    io_master.awid    = M1_ID;
    io_master.awaddr  = m1.awaddr;
    io_master.awlen   = '0;
    io_master.awsize  = m1.awsize;
    io_master.awburst = BURST_INCR;
    io_master.wvalid  = 1'b0;
    io_master.wdata   = m1.wdata;
    io_master.wstrb   = m1.wstrb;
    io_master.wlast   = 1'b1;
    io_master.bready  = 1'b0;

    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rid     = io_master.rid;
    m0.rdata   = io_master.rdata;
    m0.rresp   = io_master.rresp;
    m0.rlast   = io_master.rlast;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m0.bid     = '0;
    m0.bresp   = RESP_OKAY;

    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rid     = io_master.rid;
    m1.rdata   = io_master.rdata;
    m1.rresp   = io_master.rresp;
    m1.rlast   = io_master.rlast;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    m1.bid     = io_master.bid;
    m1.bresp   = io_master.bresp;

    unique case (state_q)
      ST_IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
`ifdef YSYX_25010008_ARB_RR_EN
        if (m0.arvalid && (m1.awvalid || m1.arvalid)) pick_m0 = (last_grant_q == GNT_M1);
        else                                          pick_m0 = m0.arvalid;
`else
        pick_m0 = m0.arvalid && !m1.awvalid && !m1.arvalid;
`endif
        if (pick_m0)          state_d = ST_RD0;
        else if (m1.awvalid)  state_d = ST_WR;
        else if (m1.arvalid)  state_d = ST_RD1;
`ifdef YSYX_25010008_ARB_RR_EN
        if (state_d != ST_IDLE) last_grant_d = pick_m0 ? GNT_M0 : GNT_M1;
`endif
      end
      ST_RD0: begin
        io_master.arvalid = !ar_done_q;
        io_master.arid    = M0_ID;
        io_master.araddr  = m0.araddr;
        io_master.arlen   = m0.arlen;
        m0.arready        = io_master.arready && !ar_done_q;
        if (!ar_done_q && io_master.arready) ar_done_d = 1'b1;
        m0.rvalid         = io_master.rvalid;
        io_master.rready  = m0.rready;
        if (io_master.rvalid && m0.rready && io_master.rlast) state_d = ST_IDLE;
      end
      ST_RD1: begin
        io_master.arvalid = !ar_done_q;
        io_master.arid    = M1_ID;
        io_master.araddr  = m1.araddr;
        io_master.arsize  = m1.arsize;
        m1.arready        = io_master.arready && !ar_done_q;
        if (!ar_done_q && io_master.arready) ar_done_d = 1'b1;
        m1.rvalid         = io_master.rvalid;
        io_master.rready  = m1.rready;
        // Single-beat read: first accepted beat ends it regardless of rlast
        if (io_master.rvalid && m1.rready) state_d = ST_IDLE;
      end
      ST_WR: begin
        io_master.awvalid = !aw_done_q;
        io_master.wvalid  = !w_done_q;
        m1.awready        = io_master.awready && !aw_done_q;
        m1.wready         = io_master.wready && !w_done_q;
        if (!aw_done_q && io_master.awready) aw_done_d = 1'b1;
        if (!w_done_q && io_master.wready)   w_done_d  = 1'b1;
        io_master.bready  = wr_both && m1.bready;
        m1.bvalid         = wr_both && io_master.bvalid;
        if (wr_both && io_master.bvalid && m1.bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25010008_axi_rr_arb.sv
// Directed self-checking bench for ysyx_25010008_axi_rr_arb.
// Expectations for contention follow YSYX_25010008_ARB_RR_EN when defined.
module tb_ysyx_25010008_axi_rr_arb;
  import ysyx_25010008_axi_rr_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ysyx_25010008_axi_rr_arb_if m0_if ();
  ysyx_25010008_axi_rr_arb_if m1_if ();
  ysyx_25010008_axi_rr_arb_if io_if ();

  ysyx_25010008_axi_rr_arb #(.M0_ID(4'd0), .M1_ID(4'd1)) dut (
    .clock     (clock),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .io_master (io_if)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = 3'b010; m0_if.arburst = 2'b01;
    m0_if.arid = '0; m0_if.rready = 0; m0_if.awvalid = 0; m0_if.awid = '0; m0_if.awaddr = '0;
    m0_if.awlen = '0; m0_if.awsize = '0; m0_if.awburst = '0; m0_if.wvalid = 0; m0_if.wdata = '0;
    m0_if.wstrb = '0; m0_if.wlast = 0; m0_if.bready = 0;
    m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = 3'b010; m1_if.arburst = 2'b01;
    m1_if.arid = '0; m1_if.rready = 0; m1_if.awvalid = 0; m1_if.awid = '0; m1_if.awaddr = '0;
    m1_if.awlen = '0; m1_if.awsize = 3'b010; m1_if.awburst = 2'b01; m1_if.wvalid = 0; m1_if.wdata = '0;
    m1_if.wstrb = '0; m1_if.wlast = 1; m1_if.bready = 0;
    io_if.arready = 0; io_if.awready = 0; io_if.wready = 0; io_if.bvalid = 0; io_if.bresp = '0;
    io_if.bid = '0; io_if.rvalid = 0; io_if.rdata = '0; io_if.rresp = '0; io_if.rlast = 0; io_if.rid = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    m0_if.arvalid = 1; m0_if.araddr = 32'h3000_0000; io_if.arready = 1;
    repeat (3) step();
    #1;
    n_checks++; if (io_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", io_if.arvalid); end
    n_checks++; if (io_if.awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid: got %b want 0", io_if.awvalid); end
    n_checks++; if (io_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_wvalid: got %b want 0", io_if.wvalid); end
    n_checks++; if ({m0_if.arready, m1_if.arready} !== 2'b00) begin n_fail++; $display("FAIL rst_arready: got %b want 00", {m0_if.arready, m1_if.arready}); end
    n_checks++; if ({io_if.rready, io_if.bready} !== 2'b00) begin n_fail++; $display("FAIL rst_rready_bready: got %b want 00", {io_if.rready, io_if.bready}); end
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    clear_inputs();
    reset = 1'b1;
    step();
  endtask

  task automatic test_m0_burst();
    m0_if.arvalid = 1; m0_if.araddr = 32'h3000_0000; m0_if.arlen = 8'd3; io_if.arready = 1;
    #1;
    n_checks++; if (io_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL m0_grant_latency: got %b want 0", io_if.arvalid); end
    step();
    #1;
    n_checks++; if (io_if.arvalid !== 1'b1) begin n_fail++; $display("FAIL m0_arvalid: got %b want 1", io_if.arvalid); end
    n_checks++; if (io_if.arid !== 4'd0) begin n_fail++; $display("FAIL m0_arid: got %h want 0", io_if.arid); end
    n_checks++; if (io_if.arlen !== 8'd3) begin n_fail++; $display("FAIL m0_arlen: got %h want 3", io_if.arlen); end
    n_checks++; if (io_if.araddr !== 32'h3000_0000) begin n_fail++; $display("FAIL m0_araddr: got %h want 30000000", io_if.araddr); end
    n_checks++; if ({io_if.arsize, io_if.arburst} !== {3'b010, 2'b01}) begin n_fail++; $display("FAIL m0_size_burst: got %b want 01001", {io_if.arsize, io_if.arburst}); end
    n_checks++; if (m0_if.arready !== 1'b1) begin n_fail++; $display("FAIL m0_arready: got %b want 1", m0_if.arready); end
    step();
    m0_if.arvalid = 0; io_if.arready = 0;
    #1;
    n_checks++; if (io_if.arvalid !== 1'b0) begin n_fail++; $display("FAIL m0_ar_once: got %b want 0", io_if.arvalid); end
    for (int i = 0; i < 4; i++) begin
      io_if.rvalid = 1; io_if.rdata = 32'hA000_0000 + 32'(i); io_if.rlast = (i == 3); io_if.rresp = 2'b00;
      m0_if.rready = 1;
      #1;
      n_checks++; if ({m0_if.rvalid, m1_if.rvalid, io_if.rready} !== 3'b101) begin n_fail++; $display("FAIL m0_beat%0d_route: got %b want 101", i, {m0_if.rvalid, m1_if.rvalid, io_if.rready}); end
      n_checks++; if (m0_if.rdata !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL m0_beat%0d_data: got %h want %h", i, m0_if.rdata, 32'hA000_0000 + 32'(i)); end
      n_checks++; if (m0_if.rlast !== (i == 3)) begin n_fail++; $display("FAIL m0_beat%0d_last: got %b want %b", i, m0_if.rlast, (i == 3)); end
      step();
    end
    io_if.rvalid = 0; io_if.rlast = 0; m0_if.rready = 0;
    #1;
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL m0_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
    n_checks++; if (m0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL m0_rvalid_after: got %b want 0", m0_if.rvalid); end
  endtask

  task automatic test_m1_store();
    m1_if.awvalid = 1; m1_if.awaddr = 32'h8000_0010; m1_if.awsize = 3'b010;
    m1_if.wvalid = 1; m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'b1111; m1_if.bready = 1;
    io_if.awready = 0; io_if.wready = 1;
    #1;
    n_checks++; if ({io_if.awvalid, io_if.wvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_grant_latency: got %b want 00", {io_if.awvalid, io_if.wvalid}); end
    step();
    #1;
    n_checks++; if ({io_if.awvalid, io_if.wvalid, io_if.wlast} !== 3'b111) begin n_fail++; $display("FAIL wr_valids: got %b want 111", {io_if.awvalid, io_if.wvalid, io_if.wlast}); end
    n_checks++; if ({io_if.awid, io_if.awlen} !== {4'd1, 8'd0}) begin n_fail++; $display("FAIL wr_id_len: got %h want 100", {io_if.awid, io_if.awlen}); end
    n_checks++; if (io_if.awaddr !== 32'h8000_0010) begin n_fail++; $display("FAIL wr_awaddr: got %h want 80000010", io_if.awaddr); end
    n_checks++; if ({io_if.wdata, io_if.wstrb} !== {32'hDEAD_BEEF, 4'hF}) begin n_fail++; $display("FAIL wr_data_strb: got %h want deadbeeff", {io_if.wdata, io_if.wstrb}); end
    n_checks++; if ({m1_if.awready, m1_if.wready} !== 2'b01) begin n_fail++; $display("FAIL wr_readies: got %b want 01", {m1_if.awready, m1_if.wready}); end
    step();
    m1_if.wvalid = 0;
    #1;
    n_checks++; if ({io_if.awvalid, io_if.wvalid, io_if.bready} !== 3'b100) begin n_fail++; $display("FAIL wr_after_w: got %b want 100", {io_if.awvalid, io_if.wvalid, io_if.bready}); end
    step();
    io_if.awready = 1;
    #1;
    n_checks++; if ({m1_if.awready, io_if.wvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_aw_late: got %b want 10", {m1_if.awready, io_if.wvalid}); end
    step();
    m1_if.awvalid = 0; io_if.awready = 0; io_if.wready = 0;
    io_if.bvalid = 1; io_if.bresp = 2'b00; io_if.bid = 4'd1;
    #1;
    n_checks++; if ({io_if.awvalid, io_if.bready, m1_if.bvalid} !== 3'b011) begin n_fail++; $display("FAIL wr_b: got %b want 011", {io_if.awvalid, io_if.bready, m1_if.bvalid}); end
    n_checks++; if (m1_if.bresp !== RESP_OKAY) begin n_fail++; $display("FAIL wr_bresp: got %b want 00", m1_if.bresp); end
    step();
    io_if.bvalid = 0; m1_if.bready = 0;
    #1;
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL wr_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_contention();
    logic       first_m0;
    logic [3:0] first_id, second_id;
    logic [1:0] first_mask, second_mask;
`ifdef YSYX_25010008_ARB_RR_EN
    first_m0 = 1'b1;
`else
    first_m0 = 1'b0;
`endif
    first_id    = first_m0 ? 4'd0 : 4'd1;
    second_id   = first_m0 ? 4'd1 : 4'd0;
    first_mask  = first_m0 ? 2'b10 : 2'b01;
    second_mask = ~first_mask;
    clear_inputs();
    reset = 1'b0; step(); reset = 1'b1; step();
    m0_if.arvalid = 1; m0_if.araddr = 32'h3000_0100; m0_if.arlen = 8'd0; m0_if.rready = 1;
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_0200; m1_if.rready = 1;
    io_if.arready = 1;
    step();
    #1;
    n_checks++; if (io_if.arid !== first_id) begin n_fail++; $display("FAIL cont_first_id: got %h want %h", io_if.arid, first_id); end
    n_checks++; if ({m0_if.arready, m1_if.arready} !== first_mask) begin n_fail++; $display("FAIL cont_first_arready: got %b want %b", {m0_if.arready, m1_if.arready}, first_mask); end
    step();
    if (first_m0) m0_if.arvalid = 0; else m1_if.arvalid = 0;
    io_if.rvalid = 1; io_if.rlast = 1; io_if.rdata = 32'h0000_0011;
    #1;
    n_checks++; if ({m0_if.rvalid, m1_if.rvalid} !== first_mask) begin n_fail++; $display("FAIL cont_first_r: got %b want %b", {m0_if.rvalid, m1_if.rvalid}, first_mask); end
    step();
    io_if.rvalid = 0;
    step();
    #1;
    n_checks++; if (io_if.arid !== second_id) begin n_fail++; $display("FAIL cont_second_id: got %h want %h", io_if.arid, second_id); end
    n_checks++; if ({m0_if.arready, m1_if.arready} !== second_mask) begin n_fail++; $display("FAIL cont_second_arready: got %b want %b", {m0_if.arready, m1_if.arready}, second_mask); end
    step();
    m0_if.arvalid = 0; m1_if.arvalid = 0;
    io_if.rvalid = 1; io_if.rlast = 1;
    #1;
    n_checks++; if ({m0_if.rvalid, m1_if.rvalid} !== second_mask) begin n_fail++; $display("FAIL cont_second_r: got %b want %b", {m0_if.rvalid, m1_if.rvalid}, second_mask); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL cont_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_m1_during_burst();
    m0_if.arvalid = 1; m0_if.araddr = 32'h3000_0040; m0_if.arlen = 8'd1; m0_if.rready = 1;
    io_if.arready = 1;
    step();
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_0300; m1_if.rready = 1;
    #1;
    n_checks++; if ({m0_if.arready, m1_if.arready} !== 2'b10) begin n_fail++; $display("FAIL hold_ar_phase: got %b want 10", {m0_if.arready, m1_if.arready}); end
    step();
    m0_if.arvalid = 0;
    for (int i = 0; i < 2; i++) begin
      io_if.rvalid = 1; io_if.rlast = (i == 1); io_if.rdata = 32'hB000_0000 + 32'(i);
      #1;
      n_checks++; if ({m1_if.arready, m1_if.rvalid, io_if.arvalid} !== 3'b000) begin n_fail++; $display("FAIL hold_beat%0d: got %b want 000", i, {m1_if.arready, m1_if.rvalid, io_if.arvalid}); end
      step();
    end
    io_if.rvalid = 0; io_if.rlast = 0;
    #1;
    n_checks++; if ({m1_if.arready, io_if.arvalid} !== 2'b00) begin n_fail++; $display("FAIL hold_idle: got %b want 00", {m1_if.arready, io_if.arvalid}); end
    step();
    #1;
    n_checks++; if ({io_if.arvalid, io_if.arid, io_if.arlen} !== {1'b1, 4'd1, 8'd0}) begin n_fail++; $display("FAIL m1_after_burst: got %h want 1100", {io_if.arvalid, io_if.arid, io_if.arlen}); end
    n_checks++; if (io_if.araddr !== 32'h8000_0300) begin n_fail++; $display("FAIL m1_after_addr: got %h want 80000300", io_if.araddr); end
    step();
    m1_if.arvalid = 0;
    io_if.rvalid = 1; io_if.rlast = 1; io_if.rdata = 32'h1234_5678;
    #1;
    n_checks++; if ({m1_if.rvalid, m0_if.rvalid, m1_if.rdata} !== {2'b10, 32'h1234_5678}) begin n_fail++; $display("FAIL m1_after_r: got %h want 212345678", {m1_if.rvalid, m0_if.rvalid, m1_if.rdata}); end
    step();
    clear_inputs();
  endtask

  task automatic test_error_resp();
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_0400; m1_if.rready = 1; io_if.arready = 1;
    step();
    step();
    m1_if.arvalid = 0;
    io_if.rvalid = 1; io_if.rresp = 2'b10; io_if.rlast = 0;
    #1;
    n_checks++; if ({m1_if.rvalid, m1_if.rresp} !== 3'b110) begin n_fail++; $display("FAIL err_rresp: got %b want 110", {m1_if.rvalid, m1_if.rresp}); end
    step();
    io_if.rvalid = 0; io_if.rresp = 2'b00;
    #1;
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL err_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
    m0_if.arvalid = 1; m0_if.araddr = 32'h3000_0080; m0_if.arlen = 8'd0; m0_if.rready = 1;
    step();
    #1;
    n_checks++; if ({io_if.arvalid, io_if.arid, m0_if.arready} !== {1'b1, 4'd0, 1'b1}) begin n_fail++; $display("FAIL err_next_grant: got %b want 100001", {io_if.arvalid, io_if.arid, m0_if.arready}); end
    step();
    m0_if.arvalid = 0;
    io_if.rvalid = 1; io_if.rlast = 1; io_if.rdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if ({m0_if.rvalid, m0_if.rresp, m0_if.rdata} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL err_next_r: got %h want 4cafef00d", {m0_if.rvalid, m0_if.rresp, m0_if.rdata}); end
    step();
    clear_inputs();
    #1;
    n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL err_next_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_m0_burst();
    test_m1_store();
    test_contention();
    test_m1_during_burst();
    test_error_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
